register_bank_r_en: RTL and testbench

Parametrised bank of DEPTH enable-gated registers, each WIDTH bits, with one write port and two registered read ports. Each entry has a valid bit, and the bank keeps a live count of valid entries. It replaces discrete 32-bit enable registers in the datapath: operands, partial products and loop counters share one bank. Reads are write-first, so the control FSM can write a result and read it back in the same cycle.

---
 rtl/register_bank_r_en_if.sv | 30 +++
 rtl/register_bank_r_en.sv | 106 ++++++++++
 tb/tb_register_bank_r_en.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/register_bank_r_en_if.sv
// Port bundle for the enable-gated register bank: one write port, two registered
// read ports, and the valid-entry count and full flag.
interface register_bank_r_en_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
);
  logic             clr;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rd_addr0;
  logic [WIDTH-1:0] rd_data0;
  logic             rd_valid0;
  logic [AW-1:0]    rd_addr1;
  logic [WIDTH-1:0] rd_data1;
  logic             rd_valid1;
  logic [AW:0]      valid_cnt;
  logic             full;

  modport master (
    output clr, wr_en, wr_addr, wr_data, rd_addr0, rd_addr1,
    input  rd_data0, rd_valid0, rd_data1, rd_valid1, valid_cnt, full
  );

  modport slave (
    input  clr, wr_en, wr_addr, wr_data, rd_addr0, rd_addr1,
    output rd_data0, rd_valid0, rd_data1, rd_valid1, valid_cnt, full
  );
endinterface

// File: rtl/register_bank_r_en.sv
// Bank of DEPTH enable-gated registers with per-entry valid bits, a live valid
// count, one write port and two write-first registered read ports.
module register_bank_r_en_entry #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             vld
);
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q   <= '0;
      vld <= 1'b0;
    end else if (we) begin
      q   <= d;
      vld <= 1'b1;
    end
  end
endmodule

module register_bank_r_en #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  register_bank_r_en_if.slave bus
);
  localparam int NRP = 2;

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] data;
  } rd_rsp_t;

  logic [DEPTH-1:0][WIDTH-1:0] ent_q;
  logic [DEPTH-1:0]            ent_v;
  logic [DEPTH-1:0]            ent_we;
  logic [NRP-1:0][AW-1:0]      rd_addr;
  rd_rsp_t [NRP-1:0]           rd_nxt;
  rd_rsp_t [NRP-1:0]           rd_q;
  logic [AW:0]                 cnt_q;
  logic                        wr_hit;
  logic                        wr_was_vld;

  // DEPTH need not be a power of two, so compare one bit wider than the address.
  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < (AW+1)'(DEPTH);
  endfunction

  assign wr_hit     = bus.wr_en && in_range(bus.wr_addr);
  assign wr_was_vld = |(ent_we & ent_v);
  assign rd_addr[0] = bus.rd_addr0;
  assign rd_addr[1] = bus.rd_addr1;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent_we[i] = wr_hit && (bus.wr_addr == AW'(i));
    register_bank_r_en_entry #(.WIDTH(WIDTH)) u_ent (
      .clk   (clk),
      .reset (reset),
      .clr   (bus.clr),
      .we    (ent_we[i]),
      .d     (bus.wr_data),
      .q     (ent_q[i]),
      .vld   (ent_v[i])
    );
  end

  // Write-first: a same-cycle write to the read address wins over the stored entry.
  always_comb begin
    rd_nxt = '0;
    for (int p = 0; p < NRP; p++) begin
      if (in_range(rd_addr[p])) begin
        if (wr_hit && (bus.wr_addr == rd_addr[p])) begin
          rd_nxt[p] = '{vld: 1'b1, data: bus.wr_data};
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr[p] == AW'(i)) rd_nxt[p] = '{vld: ent_v[i], data: ent_q[i]};
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.clr) begin
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_nxt;
      if (wr_hit && !wr_was_vld) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.rd_data0  = rd_q[0].data;
  assign bus.rd_valid0 = rd_q[0].vld;
  assign bus.rd_data1  = rd_q[1].data;
  assign bus.rd_valid1 = rd_q[1].vld;
  assign bus.valid_cnt = cnt_q;
  assign bus.full      = (cnt_q == (AW+1)'(DEPTH));
endmodule

// File: tb/tb_register_bank_r_en.sv
// Directed, table-driven checks of the register bank at DEPTH=8, plus
// hand-written sequences at DEPTH=5 for out-of-range and reset corners.
module tb_register_bank_r_en;
  logic clk = 1'b0;
  logic rst8, rst5;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  register_bank_r_en_if #(.WIDTH(32), .DEPTH(8)) if8 ();
  register_bank_r_en_if #(.WIDTH(32), .DEPTH(5)) if5 ();

  register_bank_r_en #(.WIDTH(32), .DEPTH(8)) dut8 (.clk(clk), .reset(rst8), .bus(if8));
  register_bank_r_en #(.WIDTH(32), .DEPTH(5)) dut5 (.clk(clk), .reset(rst5), .bus(if5));

  typedef struct {
    logic        clr;
    logic        we;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic [2:0]  ra0;
    logic [2:0]  ra1;
    logic [31:0] d0;
    logic        v0;
    logic [31:0] d1;
    logic        v1;
    logic [3:0]  cnt;
    logic        full;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic clr, we, input logic [2:0] wa, input logic [31:0] wd,
                              input logic [2:0] ra0, ra1, input logic [31:0] d0, input logic v0,
                              input logic [31:0] d1, input logic v1, input logic [3:0] cnt,
                              input logic full);
    vec_t v;
    v.clr = clr; v.we = we; v.wa = wa; v.wd = wd; v.ra0 = ra0; v.ra1 = ra1;
    v.d0 = d0; v.v0 = v0; v.d1 = d1; v.v1 = v1; v.cnt = cnt; v.full = full;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [31:0] d0, input logic v0,
                      input logic [31:0] d1, input logic v1, input logic [3:0] cnt, input logic full);
    chk({tag, " rd_data0"},  if8.rd_data0,  d0);
    chk({tag, " rd_valid0"}, if8.rd_valid0, v0);
    chk({tag, " rd_data1"},  if8.rd_data1,  d1);
    chk({tag, " rd_valid1"}, if8.rd_valid1, v1);
    chk({tag, " valid_cnt"}, if8.valid_cnt, cnt);
    chk({tag, " full"},      if8.full,      full);
  endtask

  task automatic chk5(input string tag, input logic [31:0] d0, input logic v0,
                      input logic [31:0] d1, input logic v1, input logic [3:0] cnt, input logic full);
    chk({tag, " rd_data0"},  if5.rd_data0,  d0);
    chk({tag, " rd_valid0"}, if5.rd_valid0, v0);
    chk({tag, " rd_data1"},  if5.rd_data1,  d1);
    chk({tag, " rd_valid1"}, if5.rd_valid1, v1);
    chk({tag, " valid_cnt"}, if5.valid_cnt, cnt);
    chk({tag, " full"},      if5.full,      full);
  endtask

  task automatic drive8(input logic clr, we, input logic [2:0] wa, input logic [31:0] wd,
                        input logic [2:0] ra0, ra1);
    if8.clr = clr; if8.wr_en = we; if8.wr_addr = wa; if8.wr_data = wd;
    if8.rd_addr0 = ra0; if8.rd_addr1 = ra1;
  endtask

  task automatic drive5(input logic we, input logic [2:0] wa, input logic [31:0] wd,
                        input logic [2:0] ra0, ra1);
    if5.clr = 1'b0; if5.wr_en = we; if5.wr_addr = wa; if5.wr_data = wd;
    if5.rd_addr0 = ra0; if5.rd_addr1 = ra1;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst8 = 1'b1;
    rst5 = 1'b1;
    drive8(1'b0, 1'b0, 3'd0, 32'h0, 3'd0, 3'd0);
    drive5(1'b0, 3'd0, 32'h0, 3'd0, 3'd0);
    cyc(); cyc();
    chk8("reset8", 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0);
    chk5("reset5", 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0);
    rst8 = 1'b0;
    rst5 = 1'b0;
    cyc(); cyc(); cyc();
    chk8("idle8", 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0);

    //           clr   we    wa    wd            ra0   ra1   d0            v0    d1            v1    cnt   full
    tbl.push_back(mk(1'b0, 1'b1, 3'd3, 32'h78,       3'd3, 3'd0, 32'h78,       1'b1, 32'h0,        1'b0, 4'd1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 3'd0, 32'h0,        3'd3, 3'd0, 32'h78,       1'b1, 32'h0,        1'b0, 4'd1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 3'd3, 32'hFFFF,     3'd3, 3'd3, 32'h78,       1'b1, 32'h78,       1'b1, 4'd1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 3'd5, 32'hDEADBEEF, 3'd5, 3'd5, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1, 4'd2, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 3'd0, 32'h100,      3'd0, 3'd3, 32'h100,      1'b1, 32'h78,       1'b1, 4'd3, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 3'd1, 32'h101,      3'd1, 3'd3, 32'h101,      1'b1, 32'h78,       1'b1, 4'd4, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 3'd2, 32'h102,      3'd2, 3'd3, 32'h102,      1'b1, 32'h78,       1'b1, 4'd5, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 3'd3, 32'h103,      3'd3, 3'd3, 32'h103,      1'b1, 32'h103,      1'b1, 4'd5, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 3'd4, 32'h104,      3'd4, 3'd5, 32'h104,      1'b1, 32'hDEADBEEF, 1'b1, 4'd6, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 3'd5, 32'h105,      3'd5, 3'd5, 32'h105,      1'b1, 32'h105,      1'b1, 4'd6, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 3'd6, 32'h106,      3'd6, 3'd7, 32'h106,      1'b1, 32'h0,        1'b0, 4'd7, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 3'd7, 32'h107,      3'd7, 3'd6, 32'h107,      1'b1, 32'h106,      1'b1, 4'd8, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 3'd0, 32'h1,        3'd0, 3'd7, 32'h1,        1'b1, 32'h107,      1'b1, 4'd8, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 3'd0, 32'h0,        3'd0, 3'd2, 32'h1,        1'b1, 32'h102,      1'b1, 4'd8, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 3'd0, 32'h0,        3'd0, 3'd7, 32'h0,        1'b0, 32'h0,        1'b0, 4'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 3'd0, 32'hA0,       3'd0, 3'd1, 32'hA0,       1'b1, 32'h0,        1'b0, 4'd1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 3'd1, 32'hA1,       3'd1, 3'd0, 32'hA1,       1'b1, 32'hA0,       1'b1, 4'd2, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 3'd2, 32'hA2,       3'd2, 3'd1, 32'hA2,       1'b1, 32'hA1,       1'b1, 4'd3, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 3'd3, 32'hA3,       3'd3, 3'd2, 32'hA3,       1'b1, 32'hA2,       1'b1, 4'd4, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 3'd6, 32'hAA,       3'd6, 3'd0, 32'h0,        1'b0, 32'h0,        1'b0, 4'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 3'd0, 32'h0,        3'd6, 3'd0, 32'h0,        1'b0, 32'h0,        1'b0, 4'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 3'd6, 32'h66,       3'd6, 3'd3, 32'h66,       1'b1, 32'h0,        1'b0, 4'd1, 1'b0));

    foreach (tbl[i]) begin
      drive8(tbl[i].clr, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra0, tbl[i].ra1);
      cyc();
      chk8($sformatf("vec%0d", i), tbl[i].d0, tbl[i].v0, tbl[i].d1, tbl[i].v1, tbl[i].cnt, tbl[i].full);
    end

    // Hold: noise on address/data with wr_en low must not disturb entry 6.
    for (int k = 0; k < 5; k++) begin
      drive8(1'b0, 1'b0, 3'd6, $urandom, 3'd6, 3'd6);
      cyc();
      chk8($sformatf("hold%0d", k), 32'h66, 1'b1, 32'h66, 1'b1, 4'd1, 1'b0);
    end
    drive8(1'b0, 1'b0, 3'd0, 32'h0, 3'd0, 3'd0);

    // DEPTH=5: addresses 5..7 are out of range.
    drive5(1'b1, 3'd7, 32'h55, 3'd7, 3'd7);
    cyc();
    chk5("oor_wr", 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0);
    drive5(1'b1, 3'd4, 32'h44, 3'd4, 3'd7);
    cyc();
    chk5("last_wr", 32'h44, 1'b1, 32'h0, 1'b0, 4'd1, 1'b0);
    drive5(1'b0, 3'd0, 32'h0, 3'd7, 3'd4);
    cyc();
    chk5("oor_rd", 32'h0, 1'b0, 32'h44, 1'b1, 4'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive5(1'b1, 3'(i), 32'h10 + 32'(i), 3'(i), 3'd4);
      cyc();
      chk5($sformatf("fill5_%0d", i), 32'h10 + 32'(i), 1'b1, 32'h44, 1'b1, 4'(i + 2), i == 3);
    end
    drive5(1'b1, 3'd2, 32'h77, 3'd2, 3'd2);
    cyc();
    chk5("ovw5", 32'h77, 1'b1, 32'h77, 1'b1, 4'd5, 1'b1);
    rst5 = 1'b1;
    drive5(1'b1, 3'd2, 32'h99, 3'd2, 3'd2);
    cyc();
    chk5("rst_wr", 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0);
    rst5 = 1'b0;
    drive5(1'b0, 3'd0, 32'h0, 3'd2, 3'd4);
    cyc();
    chk5("post_rst", 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
